serial_paralelo_alineador: RTL
==============================

Name: serial_paralelo_alineador

Overview:
Receive-side neighbour of the transmit chain's paraleloSerial stage. It deserializes the 1-bit line stream into 10-bit 8b/10b code groups and aligns word boundaries to the K28.5 comma. It tracks symbol lock with a three-state FSM and presents aligned code groups, with a valid strobe, to the downstream 8b/10b decoder.

Parameters:
COMMA_LOCK_CNT, 2, number of boundary-aligned commas needed to reach lock (legal range 1..7).
MAX_GAP, 16, number of consecutive boundary words without a comma before lock drops (legal range 2..255).

Ports:
clk  input  1  bit clock; one serial bit per rising edge.
rst  input  1  asynchronous, active-high reset.
enb  input  1  clock enable; when low, all state is frozen.
serialIn  input  1  serial line; first-transmitted bit of each code group is bit 9 (MSB first).
dataOut  output  10  aligned code group, bit 9 = first received bit.
valid  output  1  one-cycle strobe: dataOut holds a new word.
commaOut  output  1  qualifies valid; high when dataOut is K28.5.
locked  output  1  high while FSM is in LOCKED.

Behaviour:
- Reset (async, rst=1): shReg=0, bitCnt=0, commaCnt=0, gapCnt=0, state=UNLOCKED, dataOut=0, valid=0, commaOut=0, locked=0. Reset mid-word discards any partial word; re-acquisition starts from UNLOCKED.
- Shift: on each clk edge with enb=1, shReg <= {shReg[8:0], serialIn}. The combinational candidate nxt = {shReg[8:0], serialIn} is the word used by all comparisons.
- Comma match: nxt == 10'h0FA (RD-, 0011111010) or nxt == 10'h305 (RD+, 1100000101). Only K28.5 is recognised.
- Bit counter: bitCnt counts 0..9. A boundary is an edge with bitCnt==9; at a boundary bitCnt wraps to 0. A comma match that causes a realign sets bitCnt=0, which makes that edge a boundary.
- enb=0: shReg, bitCnt, all counters and state hold. valid and commaOut are driven 0. dataOut and locked hold. Alignment is preserved across enb gaps.
- UNLOCKED:
  - Comma match at any edge: realign and set commaCnt=1.
  - If COMMA_LOCK_CNT==1, go to LOCKED and emit the comma (valid=1, commaOut=1, dataOut=nxt). Otherwise go to LOCKING.
  - No output while UNLOCKED.
- LOCKING:
  - Boundary with comma: commaCnt++. When commaCnt reaches COMMA_LOCK_CNT, go to LOCKED, set gapCnt=0, and emit the comma word on the same edge.
  - Boundary without comma: ignored; no output, commaCnt holds.
  - Comma match off-boundary: realign and set commaCnt=1.
- LOCKED:
  - Every boundary: dataOut<=nxt, valid=1, commaOut=comma match.
  - Comma at boundary: gapCnt=0.
  - Boundary without comma: gapCnt++. When gapCnt reaches MAX_GAP, the word is still emitted and state goes to UNLOCKED (locked=0 from that edge).
  - Comma off-boundary: go to LOCKING, realign, commaCnt=1, no output on that edge, locked=0.
- Priority on the same edge: rst > enb=0 > off-boundary comma realign > gap timeout > normal boundary processing.
- Latency: dataOut/valid update on the same edge that captures the word's 10th bit. There is no added pipeline delay. In LOCKED, valid pulses exactly every 10 enabled cycles.
- Widths: commaCnt 3 bits, gapCnt 8 bits. Counters saturate and never wrap; they are cleared on state exit.
- All outputs are registered.

Test Plan:
1. Hold rst=1 mid-stream, then release -> all outputs 0, locked=0; next comma restarts acquisition.
2. Random bits, then 0x0FA, 0x305 back-to-back (COMMA_LOCK_CNT=2) -> no valid on the first comma; on the 10th bit of the second comma, locked=1, valid=1, dataOut=0x305, commaOut=1.
3. While locked, send 0x2AA then 0x155 -> valid strobes exactly 10 cycles apart, dataOut=0x2AA then 0x155, commaOut=0.
4. While locked, insert one extra bit, then 0x0FA -> locked=0 at the comma edge with no valid. After a further aligned 0x0FA, locked=1 and dataOut=0x0FA.
5. MAX_GAP=8, locked, send 8 data words 0x2AA -> all 8 are emitted with valid; locked=0 on the 8th word's last-bit edge; no valid afterwards.
6. Locked, drop enb for 5 cycles mid-word, then resume -> valid=0 during the gap, next word still correct (0x2AA), locked stays 1.

Source files
------------

// File: rtl/serial_paralelo_alineador.sv
// Receive-side deserializer: turns the 1-bit line into 10-bit 8b/10b code groups,
// aligns word boundaries on the K28.5 comma and tracks symbol lock.
module serial_paralelo_alineador #(
  parameter int COMMA_LOCK_CNT = 2,
  parameter int MAX_GAP        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] dataOut,
  output logic       valid,
  output logic       commaOut,
  output logic       locked
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;
  localparam logic [2:0] LOCK_LAST = 3'(COMMA_LOCK_CNT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MAX_GAP - 1);

  state_t     state_q, state_d;
  logic [9:0] sh_reg;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [9:0] nxt;
  logic       is_comma;
  logic       at_bnd;
  logic       emit;

  // The word completed by this edge's bit; every comparison looks at it.
  assign nxt      = {sh_reg[8:0], serialIn};
  assign is_comma = (nxt == K28_5_RDN) || (nxt == K28_5_RDP);
  assign at_bnd   = (bit_cnt_q == 4'd9);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = at_bnd ? 4'd0 : bit_cnt_q + 4'd1;
    comma_cnt_d = comma_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    emit        = 1'b0;

    unique case (state_q)
      UNLOCKED: begin
        if (is_comma) begin
          bit_cnt_d   = 4'd0;
          comma_cnt_d = 3'd1;
          if (COMMA_LOCK_CNT == 1) begin
            state_d     = LOCKED;
            comma_cnt_d = 3'd0;
            gap_cnt_d   = 8'd0;
            emit        = 1'b1;
          end else begin
            state_d = LOCKING;
          end
        end
      end

      LOCKING: begin
        if (is_comma && !at_bnd) begin
          bit_cnt_d   = 4'd0;
          comma_cnt_d = 3'd1;
        end else if (is_comma) begin
          if (comma_cnt_q == LOCK_LAST) begin
            state_d     = LOCKED;
            comma_cnt_d = 3'd0;
            gap_cnt_d   = 8'd0;
            emit        = 1'b1;
          end else if (comma_cnt_q != 3'd7) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
          end
        end
      end

      LOCKED: begin
        // A comma off the current grid means the boundary slipped: re-acquire.
        if (is_comma && !at_bnd) begin
          state_d     = LOCKING;
          bit_cnt_d   = 4'd0;
          comma_cnt_d = 3'd1;
          gap_cnt_d   = 8'd0;
        end else if (at_bnd) begin
          emit = 1'b1;
          if (is_comma) begin
            gap_cnt_d = 8'd0;
          end else if (gap_cnt_q == GAP_LAST) begin
            state_d     = UNLOCKED;
            gap_cnt_d   = 8'd0;
            comma_cnt_d = 3'd0;
          end else if (gap_cnt_q != 8'hFF) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d     = UNLOCKED;
        comma_cnt_d = 3'd0;
        gap_cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      sh_reg      <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      gap_cnt_q   <= '0;
      dataOut     <= '0;
      valid       <= 1'b0;
      commaOut    <= 1'b0;
      locked      <= 1'b0;
    end else if (enb) begin
      state_q     <= state_d;
      sh_reg      <= nxt;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      valid       <= emit;
      commaOut    <= emit && is_comma;
      locked      <= (state_d == LOCKED);
      if (emit) dataOut <= nxt;
    end else begin
      // Frozen cycle: strobes drop, data and lock status hold.
      valid    <= 1'b0;
      commaOut <= 1'b0;
    end
  end

endmodule
